// File: rtl/mbist_march_ctrl.sv
// March SR+ memory BIST controller for a single-port synchronous SRAM.
// Runs E0..E5 over the whole address space and stops on the first read miscompare.
module mbist_march_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  test_done,
  output logic                  fail_flag,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [1:0]            dbg_state
);

  // start is a one-cycle pulse with no ready: it is taken only in IDLE or DONE,
  // and mem_cs/we/re describe the op the SRAM samples on the edge ending that cycle.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int                  WAIT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [2:0]          LAST_ELEM = 3'd5;

  state_t                  state_q;
  logic [2:0]              elem_q;
  logic [1:0]              op_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WAIT_W-1:0]       wait_q;
  logic                    cs_q;
  logic                    we_q;
  logic                    re_q;
  logic [ADDR_WIDTH-1:0]   maddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    done_q;
  logic                    fail_q;
  logic [ADDR_WIDTH-1:0]   faddr_q;

  logic [2:0]              elem_d;
  logic [1:0]              op_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic                    last_step;
  logic                    at_end;
  logic                    cur_rd;
  logic                    rd_match;
  logic                    wait_last;
  logic                    adv;
  logic                    iss_rd;
  logic [DATA_WIDTH-1:0]   iss_wdata;
  logic [DATA_WIDTH-1:0]   exp_word;

  // Index of the last op in each element: E0 w0 | E1 r0 w1 r1 w0 | E2 r0 r0 | E3 w1 | E4 r1 w0 r0 w1 | E5 r1 r1
  function automatic logic [1:0] last_op(input logic [2:0] e);
    case (e)
      3'd1, 3'd4: last_op = 2'd3;
      3'd2, 3'd5: last_op = 2'd1;
      default:    last_op = 2'd0;
    endcase
  endfunction

  function automatic logic elem_down(input logic [2:0] e);
    elem_down = (e == 3'd0) || (e == 3'd4) || (e == 3'd5);
  endfunction

  function automatic logic op_rd(input logic [2:0] e, input logic [1:0] o);
    case (e)
      3'd1, 3'd4: op_rd = (o == 2'd0) || (o == 2'd2);
      3'd2, 3'd5: op_rd = 1'b1;
      default:    op_rd = 1'b0;
    endcase
  endfunction

  function automatic logic op_val(input logic [2:0] e, input logic [1:0] o);
    case (e)
      3'd1:       op_val = (o == 2'd1) || (o == 2'd2);
      3'd3, 3'd5: op_val = 1'b1;
      3'd4:       op_val = (o == 2'd0) || (o == 2'd3);
      default:    op_val = 1'b0;
    endcase
  endfunction

  assign at_end    = elem_down(elem_q) ? (addr_q == '0) : (addr_q == ADDR_MAX);
  assign cur_rd    = op_rd(elem_q, op_q);
  assign exp_word  = op_val(elem_q, op_q) ? '1 : '0;
  assign rd_match  = (mem_rdata == exp_word);
  assign wait_last = (wait_q == WAIT_W'(READ_LATENCY - 1));
  assign adv       = ((state_q == RUN) && !cur_rd) ||
                     ((state_q == WAIT_RD) && wait_last && rd_match);

  // Position of the op that follows the current one; the address reloads for the
  // next element's direction only after the terminal address, so it never wraps.
  always_comb begin
    elem_d    = elem_q;
    op_d      = op_q;
    addr_d    = addr_q;
    last_step = 1'b0;
    if (op_q != last_op(elem_q)) begin
      op_d = op_q + 2'd1;
    end else if (!at_end) begin
      op_d   = '0;
      addr_d = elem_down(elem_q) ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);
    end else if (elem_q != LAST_ELEM) begin
      elem_d = elem_q + 3'd1;
      op_d   = '0;
      addr_d = elem_down(elem_d) ? ADDR_MAX : '0;
    end else begin
      last_step = 1'b1;
    end
  end

  assign iss_rd    = op_rd(elem_d, op_d);
  assign iss_wdata = (!iss_rd && op_val(elem_d, op_d)) ? '1 : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      elem_q  <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wait_q  <= '0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      faddr_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            elem_q  <= '0;
            op_q    <= '0;
            addr_q  <= ADDR_MAX;
            wait_q  <= '0;
            cs_q    <= 1'b1;
            we_q    <= 1'b1;
            re_q    <= 1'b0;
            maddr_q <= ADDR_MAX;
            wdata_q <= '0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            faddr_q <= '0;
          end
        end
        RUN: begin
          if (cur_rd) begin
            state_q <= WAIT_RD;
            wait_q  <= '0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
          end
        end
        WAIT_RD: begin
          if (!wait_last) begin
            wait_q <= wait_q + WAIT_W'(1);
          end else if (!rd_match) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            fail_q  <= 1'b1;
            faddr_q <= addr_q;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (adv) begin
        if (last_step) begin
          state_q <= DONE;
          done_q  <= 1'b1;
          cs_q    <= 1'b0;
          we_q    <= 1'b0;
          re_q    <= 1'b0;
          maddr_q <= '0;
          wdata_q <= '0;
        end else begin
          state_q <= RUN;
          elem_q  <= elem_d;
          op_q    <= op_d;
          addr_q  <= addr_d;
          cs_q    <= 1'b1;
          we_q    <= !iss_rd;
          re_q    <= iss_rd;
          maddr_q <= addr_d;
          wdata_q <= iss_wdata;
        end
      end
    end
  end

  assign mem_cs    = cs_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;
  assign test_done = done_q;
  assign fail_flag = fail_q;
  assign fail_addr = faddr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: faulty SRAM models, a march-level reference that
// predicts the op stream and first failing address, and directed/random runs.
module tb_mbist_march_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NA = 1 << AW;
  localparam logic [DW-1:0] ONES = '1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic start;
  logic start2;

  // instance 1: READ_LATENCY = 1, fault-injecting memory
  logic          cs1, we1, re1, done1, fail1;
  logic [AW-1:0] addr1, faddr1;
  logic [DW-1:0] wdata1, rdata1;
  logic [1:0]    dbg1;
  // instance 2: READ_LATENCY = 2, fault-free memory
  logic          cs2, we2, re2, done2, fail2;
  logic [AW-1:0] addr2, faddr2;
  logic [DW-1:0] wdata2, rdata2;
  logic [1:0]    dbg2;

  mbist_march_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start),
    .mem_cs(cs1), .mem_we(we1), .mem_re(re1), .mem_addr(addr1),
    .mem_wdata(wdata1), .mem_rdata(rdata1),
    .test_done(done1), .fail_flag(fail1), .fail_addr(faddr1), .dbg_state(dbg1)
  );

  mbist_march_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2),
    .mem_cs(cs2), .mem_we(we2), .mem_re(re2), .mem_addr(addr2),
    .mem_wdata(wdata2), .mem_rdata(rdata2),
    .test_done(done2), .fail_flag(fail2), .fail_addr(faddr2), .dbg_state(dbg2)
  );

  // ---------------- scoreboard state ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [11:0] exp_q[$];
  logic        mon_en = 1'b0;
  int          ops2 = 0;

  // fault: 0 none, 1 stuck-at-0 at fa, 2 up-transition at fa, 3 coupling fa -> fv
  int         fault_type = 0;
  logic [7:0] fa = '0;
  logic [7:0] fv = '0;

  logic [DW-1:0] mem1 [NA];
  logic [DW-1:0] mem2 [NA];
  logic [DW-1:0] st2;
  logic          v2;

  // Memory 1: rdata holds the read value only in the cycle after the read edge.
  always @(posedge clk) begin
    if (cs1 && we1) begin
      if (fault_type == 1 && addr1 == fa)
        mem1[addr1] <= '0;
      else if (!(fault_type == 2 && addr1 == fa && mem1[addr1] == '0 && wdata1 != '0))
        mem1[addr1] <= wdata1;
      if (fault_type == 3 && addr1 == fa && wdata1 == ONES)
        mem1[fv] <= ~mem1[fv];
    end
    rdata1 <= (cs1 && re1) ? mem1[addr1] : DW'($urandom);
  end

  // Memory 2: two-stage read path; data is valid only in the cycle before the second edge.
  always @(posedge clk) begin
    if (cs2 && we2) mem2[addr2] <= wdata2;
    st2    <= (cs2 && re2) ? mem2[addr2] : DW'($urandom);
    v2     <= cs2 && re2;
    rdata2 <= v2 ? st2 : DW'($urandom);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Op stream monitor for instance 1 against the reference op queue.
  always @(negedge clk) begin
    logic        bitv;
    logic [11:0] code;
    if (cs2) ops2++;
    if (mon_en && (cs1 || we1 || re1)) begin
      bitv = !we1 ? 1'b0 : (wdata1 == ONES) ? 1'b1 : (wdata1 == '0) ? 1'b0 : 1'bx;
      code = {cs1, re1, we1, bitv, addr1};
      if (exp_q.size() == 0) check("op_extra", 64'(code), 64'd0);
      else check("op_seq", 64'(code), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- reference model ----------------
  // Walks the March SR+ table over a one-bit-per-cell faulty memory, queues every
  // expected op and stops at the first read that disagrees with its background.
  task automatic build_ref(output logic exp_fail, output logic [7:0] exp_faddr);
    bit m [NA];
    int n_ops [6] = '{1, 4, 2, 1, 4, 2};
    bit dn [6]    = '{1, 0, 0, 0, 1, 1};
    bit rd [6][4] = '{'{0,0,0,0}, '{1,0,1,0}, '{1,1,0,0}, '{0,0,0,0}, '{1,0,1,0}, '{1,1,0,0}};
    bit vl [6][4] = '{'{0,0,0,0}, '{0,1,1,0}, '{0,0,0,0}, '{1,0,0,0}, '{1,0,0,1}, '{1,1,0,0}};
    int a;
    bit v;
    exp_q.delete();
    exp_fail  = 1'b0;
    exp_faddr = '0;
    for (int i = 0; i < NA; i++) m[i] = (fault_type == 1 && i == int'(fa)) ? 1'b0 : 1'($urandom_range(0, 1));
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < NA; k++) begin
        a = dn[e] ? NA - 1 - k : k;
        for (int o = 0; o < n_ops[e]; o++) begin
          v = vl[e][o];
          if (rd[e][o]) begin
            exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 8'(a)});
            if (m[a] != v) begin
              exp_fail  = 1'b1;
              exp_faddr = 8'(a);
              return;
            end
          end else begin
            exp_q.push_back({1'b1, 1'b0, 1'b1, v, 8'(a)});
            if (!(fault_type == 1 && a == int'(fa)) && !(fault_type == 2 && a == int'(fa) && !m[a] && v))
              m[a] = v;
            if (fault_type == 3 && a == int'(fa) && v) m[fv] = !m[fv];
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse(input int sel);
    @(negedge clk);
    if (sel == 1) start = 1'b1;
    else start2 = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  // Counts cycles from the start edge until test_done is seen (bounded).
  task automatic wait_done(input string tag, input int sel, input int bound, output int cyc);
    logic d;
    cyc = 1;
    d   = 1'b0;
    while (!d && cyc <= bound) begin
      @(negedge clk);
      d = (sel == 1) ? done1 : done2;
      if (!d) cyc++;
    end
    check(tag, 64'(d), 64'd1);
  endtask

  task automatic check_quiet1(input string tag);
    check({tag, "_cs"},    64'(cs1),    64'd0);
    check({tag, "_we"},    64'(we1),    64'd0);
    check({tag, "_re"},    64'(re1),    64'd0);
    check({tag, "_addr"},  64'(addr1),  64'd0);
    check({tag, "_wdata"}, 64'(wdata1), 64'd0);
    check({tag, "_done"},  64'(done1),  64'd0);
    check({tag, "_fail"},  64'(fail1),  64'd0);
    check({tag, "_faddr"}, 64'(faddr1), 64'd0);
  endtask

  task automatic run1(input string tag, input int ft, input logic [7:0] a, input logic [7:0] v, output int cyc);
    logic       ef;
    logic [7:0] efa;
    fault_type = ft;
    fa = a;
    fv = v;
    build_ref(ef, efa);
    pulse(1);
    wait_done({tag, "_done"}, 1, 6000, cyc);
    check({tag, "_fail_flag"}, 64'(fail1), 64'(ef));
    check({tag, "_fail_addr"}, 64'(faddr1), 64'(efa));
    check({tag, "_ops_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_ctrl_idle"}, 64'({cs1, we1, re1}), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         cyc;
    int         ft;
    logic [7:0] ra;
    logic [7:0] rv;
    int         ops2_base;

    reset_n = 1'b0;
    start   = 1'b0;
    start2  = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet1("reset");
    check("reset_dbg1", 64'(dbg1), 64'd0);
    check("reset_inst2", 64'({cs2, we2, re2, addr2, wdata2, done2, fail2, faddr2}), 64'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (2) @(negedge clk);

    // fault-free: 14 ops plus one wait per read (8 reads) per address
    run1("clean", 0, 8'd0, 8'd0, cyc);
    check("clean_cycles", 64'(cyc), 64'(14 * NA + 8 * NA));
    check("clean_fail_zero", 64'({fail1, faddr1}), 64'd0);

    run1("sa0_12", 1, 8'd12, 8'd0, cyc);
    check("sa0_12_addr", 64'(faddr1), 64'd12);
    run1("uptf_45", 2, 8'd45, 8'd0, cyc);
    check("uptf_45_addr", 64'(faddr1), 64'd45);
    run1("cf_100_101", 3, 8'd100, 8'd101, cyc);
    check("cf_100_101_addr", 64'(faddr1), 64'd101);
    check("cf_flag", 64'(fail1), 64'd1);

    // randomized faults
    for (int it = 0; it < 4; it++) begin
      ft = $urandom_range(0, 3);
      ra = 8'($urandom_range(0, NA - 1));
      rv = ra ^ 8'($urandom_range(1, NA - 1));
      run1("rand", ft, ra, rv, cyc);
    end

    // start pulses during a run are ignored: one clean pass, then held
    fault_type = 0;
    begin
      logic       ef;
      logic [7:0] efa;
      build_ref(ef, efa);
      pulse(1);
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(50, 800)) @(negedge clk);
        pulse(1);
      end
      wait_done("ignore_done", 1, 6000, cyc);
      check("ignore_fail", 64'(fail1), 64'(ef));
      check("ignore_ops_left", 64'(exp_q.size()), 64'd0);
      repeat (20) @(negedge clk);
      check("ignore_done_held", 64'(done1), 64'd1);
    end

    // reset in the middle of a second run
    begin
      logic       ef;
      logic [7:0] efa;
      build_ref(ef, efa);
      pulse(1);
      repeat ($urandom_range(100, 3000)) @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check_quiet1("midrun_reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete();
      repeat (50) @(negedge clk);
      check("post_reset_no_done", 64'(done1), 64'd0);
      check("post_reset_no_ops", 64'({cs1, we1, re1}), 64'd0);
    end
    ra = 8'($urandom_range(0, NA - 1));
    run1("post_reset_sa0", 1, ra, 8'd0, cyc);
    check("post_reset_sa0_addr", 64'(faddr1), 64'(ra));

    // READ_LATENCY = 2: data only valid exactly two edges after each read edge
    ops2_base = ops2;
    pulse(2);
    wait_done("rl2_done", 2, 9000, cyc);
    check("rl2_fail", 64'(fail2), 64'd0);
    check("rl2_faddr", 64'(faddr2), 64'd0);
    check("rl2_cycles", 64'(cyc), 64'(14 * NA + 8 * NA * 2));
    check("rl2_ops", 64'(ops2 - ops2_base), 64'(14 * NA));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
